// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU.
// Results are registered; sign correction is applied in FINISH and overridden on divide-by-zero.
module div_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        is_signed,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        div_by_zero
);
   localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FINISH = 2'd2;
   logic [1:0]  state;
   logic [5:0]  cnt;
   logic [32:0] prem;
   logic [31:0] qsh, dvs, dvd_raw;
   logic        q_neg, r_neg, dz;
   logic [31:0] a_mag, b_mag;
   logic [32:0] shifted, diff;
   always_comb begin
      a_mag   = (is_signed && dividend[31]) ? -dividend : dividend;
      b_mag   = (is_signed && divisor[31]) ? -divisor : divisor;
      shifted = {prem[31:0], qsh[31]};
      diff    = shifted - {1'b0, dvs};
   end
   assign busy = (state == CALC) || (state == FINISH);
   // qsh holds the remaining dividend bits on the left and collects quotient bits on the right
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         prem        <= '0;
         qsh         <= '0;
         dvs         <= '0;
         dvd_raw     <= '0;
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
         dz          <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         if (flush) state <= IDLE;
         else case (state)
            IDLE: if (start) begin
               dvs     <= b_mag;
               qsh     <= a_mag;
               dvd_raw <= dividend;
               q_neg   <= is_signed & (dividend[31] ^ divisor[31]);
               r_neg   <= is_signed & dividend[31];
               dz      <= (divisor == 32'd0);
               cnt     <= '0;
               prem    <= '0;
               state   <= CALC;
            end
            CALC: begin
               prem  <= diff[32] ? shifted : diff;
               qsh   <= {qsh[30:0], ~diff[32]};
               cnt   <= cnt + 6'd1;
               state <= (cnt == 6'd31) ? FINISH : CALC;
            end
            FINISH: begin
               quotient    <= dz ? 32'hFFFF_FFFF : (q_neg ? -qsh : qsh);
               remainder   <= dz ? dvd_raw : (r_neg ? -prem[31:0] : prem[31:0]);
               div_by_zero <= dz;
               done        <= 1'b1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit; expected results come from a reference model.
module tb_div_unit;
   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        z;
   } res_t;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        is_signed = 1'b0;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic        flush = 1'b0;
   logic        busy, done, div_by_zero;
   logic [31:0] quotient, remainder;
   res_t        sb[$];
   res_t        last;
   res_t        exp;
   int          checks = 0;
   int          errors = 0;
   always #5 clk = ~clk;
   div_unit dut (
      .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
      .dividend(dividend), .divisor(divisor), .flush(flush), .busy(busy),
      .done(done), .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
   );
   function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
      res_t o;
      int   sa, sd;
      if (b == 0) begin
         o.q = 32'hFFFF_FFFF; o.r = a; o.z = 1'b1;
      end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         o.q = 32'h8000_0000; o.r = 0; o.z = 1'b0;
      end else if (s) begin
         sa = a; sd = b;
         o.q = sa / sd; o.r = sa % sd; o.z = 1'b0;
      end else begin
         o.q = a / b; o.r = a % b; o.z = 1'b0;
      end
      return o;
   endfunction
   // drive one request; caller sits just after a rising edge, returns at E0 + 1
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input bit push);
      dividend = a; divisor = b; is_signed = s; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (push) sb.push_back(model(a, b, s));
   endtask
   task automatic wait_done(output int lat, output int bcnt);
      lat = 0; bcnt = 0;
      while (lat < 40) begin
         if (busy) bcnt++;
         @(posedge clk); #1;
         lat++;
         if (done) break;
      end
   endtask
   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, quotient, remainder, div_by_zero} !== 67'd0) begin
         errors++;
         $display("FAIL reset_state got busy=%b done=%b q=%h r=%h z=%b want all zero", busy, done, quotient, remainder, div_by_zero);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask
   task automatic test_ops(input string name, input logic [31:0] a[], input logic [31:0] b[], input logic s[]);
      int lat, bcnt;
      foreach (a[i]) begin
         issue(a[i], b[i], s[i], 1'b1);
         wait_done(lat, bcnt);
         checks++;
         if (lat !== 33 || bcnt !== 33) begin
            errors++;
            $display("FAIL %s_latency[%0d] got lat=%0d busy=%0d want 33/33", name, i, lat, bcnt);
         end
         exp = sb.pop_front();
         last = exp;
         checks++;
         if ({quotient, remainder, div_by_zero} !== {exp.q, exp.r, exp.z}) begin
            errors++;
            $display("FAIL %s_result[%0d] got q=%h r=%h z=%b want q=%h r=%h z=%b", name, i, quotient, remainder, div_by_zero, exp.q, exp.r, exp.z);
         end
         @(posedge clk); #1;
         checks++;
         if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse[%0d] got done=%b want 0", name, i, done);
         end
      end
   endtask
   task automatic test_unsigned;
      test_ops("unsigned", '{32'd100, 32'hFFFF_FFFF}, '{32'd7, 32'd1}, '{1'b0, 1'b0});
      checks++;
      if ({last.q, last.r} !== {32'hFFFF_FFFF, 32'd0}) begin
         errors++;
         $display("FAIL model_unsigned_max got q=%h r=%h want ffffffff/0", last.q, last.r);
      end
   endtask
   task automatic test_signed;
      test_ops("signed", '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000}, '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF}, '{1'b1, 1'b1, 1'b1});
   endtask
   task automatic test_div_zero;
      test_ops("div_zero", '{32'h1234_5678, 32'h1234_5678, 32'h8765_4321}, '{32'd0, 32'd0, 32'd0}, '{1'b0, 1'b1, 1'b1});
   endtask
   task automatic test_random;
      logic [31:0] a[] = new[12];
      logic [31:0] b[] = new[12];
      logic        s[] = new[12];
      foreach (a[i]) begin
         a[i] = $urandom;
         b[i] = (i % 3 == 0) ? $urandom_range(1, 300) : $urandom;
         s[i] = i[0];
      end
      test_ops("random", a, b, s);
   endtask
   task automatic test_start_ignored;
      int lat, bcnt, n;
      issue(32'd1000, 32'd9, 1'b0, 1'b1);
      repeat (9) @(posedge clk);
      #1;
      dividend = 32'd55; divisor = 32'd5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(lat, bcnt);
      checks++;
      if (lat + 10 !== 33) begin
         errors++;
         $display("FAIL ignore_latency got %0d want 33", lat + 10);
      end
      exp = sb.pop_front();
      last = exp;
      checks++;
      if ({quotient, remainder, div_by_zero} !== {exp.q, exp.r, exp.z}) begin
         errors++;
         $display("FAIL ignore_result got q=%h r=%h z=%b want q=%h r=%h z=%b", quotient, remainder, div_by_zero, exp.q, exp.r, exp.z);
      end
      n = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) n++;
      end
      checks++;
      if (n !== 0) begin
         errors++;
         $display("FAIL ignore_extra_done got %0d want 0", n);
      end
   endtask
   task automatic test_back_to_back;
      int lat, bcnt;
      issue(32'd500, 32'd20, 1'b0, 1'b1);
      wait_done(lat, bcnt);
      exp = sb.pop_front();
      checks++;
      if (lat !== 33 || {quotient, remainder} !== {exp.q, exp.r}) begin
         errors++;
         $display("FAIL b2b_first got lat=%0d q=%h r=%h want 33 q=%h r=%h", lat, quotient, remainder, exp.q, exp.r);
      end
      issue(32'hFFFF_FF00, 32'd3, 1'b1, 1'b1);
      wait_done(lat, bcnt);
      exp = sb.pop_front();
      last = exp;
      checks++;
      if (lat !== 33 || {quotient, remainder, div_by_zero} !== {exp.q, exp.r, exp.z}) begin
         errors++;
         $display("FAIL b2b_second got lat=%0d q=%h r=%h z=%b want 33 q=%h r=%h z=%b", lat, quotient, remainder, div_by_zero, exp.q, exp.r, exp.z);
      end
   endtask
   task automatic test_flush;
      int n;
      issue(32'd77, 32'd0, 1'b0, 1'b0);
      repeat (14) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      checks++;
      if (busy !== 1'b0 || {quotient, remainder, div_by_zero} !== {last.q, last.r, last.z}) begin
         errors++;
         $display("FAIL flush_state got busy=%b q=%h r=%h z=%b want 0 q=%h r=%h z=%b", busy, quotient, remainder, div_by_zero, last.q, last.r, last.z);
      end
      flush = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; start = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL flush_priority got busy=%b want 0", busy);
      end
      n = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) n++;
      end
      checks++;
      if (n !== 0) begin
         errors++;
         $display("FAIL flush_no_done got %0d want 0", n);
      end
   endtask
   task automatic test_async_reset;
      int n;
      issue(32'd999, 32'd4, 1'b0, 1'b0);
      repeat (5) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, quotient, remainder, div_by_zero} !== 67'd0) begin
         errors++;
         $display("FAIL async_reset got busy=%b done=%b q=%h r=%h z=%b want all zero", busy, done, quotient, remainder, div_by_zero);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      n = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done || busy) n++;
      end
      checks++;
      if (n !== 0) begin
         errors++;
         $display("FAIL async_reset_no_done got %0d active cycles want 0", n);
      end
   endtask
   initial begin
      test_reset;
      test_unsigned;
      test_signed;
      test_div_zero;
      test_random;
      test_start_ignored;
      test_back_to_back;
      test_flush;
      test_async_reset;
      checks++;
      if (sb.size() !== 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
